// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS front end.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2
  } fetch_state_t;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] PC_INCR          = 32'd4;

endpackage

// File: rtl/instr_fetch_next_pc_sel.sv
// Next-PC selection for the fetch stage: jump > taken branch > sequential.
module next_pc_sel
  import mips_pkg::*;
(
  input  logic [31:0] pc_plus4,
  input  logic [31:0] imm,
  input  logic [25:0] jump_target,
  input  logic        jump,
  input  logic        branch_taken,
  output logic [31:0] next_pc
);

  // Word offset; the shift drops imm[31:30], which are redundant sign bits.
  logic [31:0] br_off;
  assign br_off = imm << 2;

  always_comb begin
    next_pc = pc_plus4;
    if (jump)
      next_pc = {pc_plus4[31:28], jump_target, 2'b00};
    else if (branch_taken)
      next_pc = pc_plus4 + br_off;
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: holds the PC, fetches over req/ack and hands the
// word to decode, advancing the PC when decode accepts it.
module instr_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] pc_plus4,
  output logic        instr_valid,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] imm,
  input  logic        jump,
  input  logic [25:0] jump_target
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  instr_pc_q, instr_pc_d;
  logic         valid_q, valid_d;
  logic [31:0]  next_pc;

  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = valid_q;
  assign pc_plus4    = instr_pc_q + PC_INCR;

  next_pc_sel u_next_pc_sel (
    .pc_plus4     (pc_plus4),
    .imm          (imm),
    .jump_target  (jump_target),
    .jump         (jump),
    .branch_taken (branch_taken),
    .next_pc      (next_pc)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    imem_req   = 1'b0;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          instr_d    = imem_rdata;
          instr_pc_d = pc_q;
          valid_d    = 1'b1;
          state_d    = VALID;
        end
      end
      VALID: begin
        if (!stall) begin
          pc_d    = {next_pc[31:2], 2'b00};
          valid_d = 1'b0;
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= {RESET_PC[31:2], 2'b00};
      instr_q    <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a scoreboard of expected hand-offs.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] pc_plus4;
  logic        instr_valid;
  logic        stall;
  logic        branch_taken;
  logic [31:0] imm;
  logic        jump;
  logic [25:0] jump_target;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // {instr, instr_pc} expected at each hand-off
  logic [63:0] exp_q[$];

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .instr        (instr),
    .instr_pc     (instr_pc),
    .pc_plus4     (pc_plus4),
    .instr_valid  (instr_valid),
    .stall        (stall),
    .branch_taken (branch_taken),
    .imm          (imm),
    .jump         (jump),
    .jump_target  (jump_target)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One full fetch: wait for the request, ack after dly cycles, hold for stl
  // stall cycles, then accept with the given redirect controls.
  task automatic fetch(input logic [31:0] exp_addr, input logic [31:0] rdata,
                       input int dly, input int stl,
                       input logic j, input logic b,
                       input logic [31:0] im, input logic [25:0] jt);
    logic [63:0] e;
    int n;
    n = 0;
    while (!imem_req && n < 10) begin
      tick();
      n++;
    end
    chk("req_seen", {31'd0, imem_req}, 32'd1);
    chk("req_addr", imem_addr, exp_addr);
    for (int i = 0; i < dly; i++) begin
      tick();
      chk("wait_req", {31'd0, imem_req}, 32'd1);
      chk("wait_addr", imem_addr, exp_addr);
      chk("wait_novalid", {31'd0, instr_valid}, 32'd0);
    end
    imem_ack   = 1'b1;
    imem_rdata = rdata;
    exp_q.push_back({rdata, exp_addr});
    tick();
    imem_ack   = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    chk("valid_set", {31'd0, instr_valid}, 32'd1);
    chk("req_drop", {31'd0, imem_req}, 32'd0);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("instr", instr, e[63:32]);
      chk("instr_pc", instr_pc, e[31:0]);
      chk("pc_plus4", pc_plus4, e[31:0] + 32'd4);
    end
    for (int i = 0; i < stl; i++) begin
      stall      = 1'b1;
      imem_ack   = 1'b1;             // must be ignored while holding
      imem_rdata = 32'h0BAD_0BAD;
      tick();
      chk("stall_valid", {31'd0, instr_valid}, 32'd1);
      chk("stall_instr", instr, rdata);
      chk("stall_noreq", {31'd0, imem_req}, 32'd0);
    end
    imem_ack     = 1'b0;
    stall        = 1'b0;
    jump         = j;
    branch_taken = b;
    imm          = im;
    jump_target  = jt;
    tick();
    jump         = 1'b0;
    branch_taken = 1'b0;
    imm          = 32'h1234_5678;
    jump_target  = 26'h3FF_FFFF;
    chk("accept_clr", {31'd0, instr_valid}, 32'd0);
  endtask

  initial begin
    rst          = 1'b1;
    imem_ack     = 1'b0;
    imem_rdata   = 32'h0;
    stall        = 1'b0;
    branch_taken = 1'b0;
    imm          = 32'h0;
    jump         = 1'b0;
    jump_target  = 26'h0;
    tick();
    tick();
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_instr_pc", instr_pc, 32'd0);

    rst = 1'b0;
    chk("idle_req", {31'd0, imem_req}, 32'd0);
    tick();
    chk("first_req", {31'd0, imem_req}, 32'd1);

    // back-to-back fetch with ack in the request cycle
    fetch(32'h0000_0000, 32'h2008_0005, 0, 0, 1'b0, 1'b0, 32'h0, 26'h0);
    // slow memory plus stall, then jump to 0x40
    fetch(32'h0000_0004, 32'h1111_0004, 3, 4, 1'b1, 1'b0, 32'h0, 26'h000_0010);
    // backward branch
    fetch(32'h0000_0040, 32'h1000_FFFE, 0, 0, 1'b0, 1'b1, 32'hFFFF_FFFE, 26'h0);
    fetch(32'h0000_003C, 32'h0800_0010, 1, 0, 1'b1, 1'b0, 32'h0, 26'h000_0010);
    // forward branch
    fetch(32'h0000_0040, 32'h1000_0010, 0, 1, 1'b0, 1'b1, 32'h0000_0010, 26'h0);
    // branch to the top word of the address space
    fetch(32'h0000_0084, 32'h1000_FFDD, 0, 0, 1'b0, 1'b1, 32'hFFFF_FFDD, 26'h0);
    // sequential wrap
    fetch(32'hFFFF_FFFC, 32'h2222_FFFC, 2, 0, 1'b0, 1'b0, 32'h0, 26'h0);
    fetch(32'h0000_0000, 32'h1000_0FFF, 0, 0, 1'b0, 1'b1, 32'h03FF_FFFF, 26'h0);
    // jump beats branch
    fetch(32'h1000_0000, 32'h0800_0100, 0, 2, 1'b1, 1'b1, 32'h0000_0010, 26'h000_0100);

    // reset mid-FETCH; ack arrives while back in IDLE
    chk("pre_rst_req", {31'd0, imem_req}, 32'd1);
    chk("pre_rst_addr", imem_addr, 32'h1000_0400);
    rst = 1'b1;
    tick();
    chk("rst_mid_req", {31'd0, imem_req}, 32'd0);
    chk("rst_mid_valid", {31'd0, instr_valid}, 32'd0);
    rst        = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 32'hBADB_ADBA;
    tick();
    imem_ack   = 1'b0;
    chk("idle_ack_valid", {31'd0, instr_valid}, 32'd0);
    chk("idle_ack_req", {31'd0, imem_req}, 32'd1);
    chk("idle_ack_addr", imem_addr, 32'h0000_0000);
    fetch(32'h0000_0000, 32'h3333_0000, 0, 0, 1'b0, 1'b0, 32'h0, 26'h0);
    chk("post_req_addr", imem_addr, 32'h0000_0004);
    chk("sb_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage for the 32-bit MIPS core. It holds the program counter and requests instructions from instruction memory over a req/ack handshake. It presents each fetched word to decode, whose low 16 bits drive the sign-extension stage. On hand-off it computes the next PC from PC+4, the sign-extended branch immediate, or a jump target.

## Interface

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word aligned.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  32  fetch address; equals current PC.
- imem_ack  input  1  memory returns data this cycle; may assert in the same cycle as imem_req.
- imem_rdata  input  32  instruction word; valid when imem_ack=1.
- instr  output  32  held instruction; [15:0] feeds the sign-extension stage.
- instr_pc  output  32  address of instr.
- pc_plus4  output  32  instr_pc + 4; used for the link register.
- instr_valid  output  1  instr/instr_pc are valid.
- stall  input  1  downstream not ready; the instruction is consumed on a cycle with instr_valid=1 and stall=0.
- branch_taken  input  1  decode/ALU resolved a taken branch for the held instruction.
- imm  input  32  sign-extended immediate of the held instruction.
- jump  input  1  held instruction is J/JAL.
- jump_target  input  26  instr[25:0] of the held instruction.

## Operation

- States: IDLE, FETCH, VALID.
- Reset (rst=1 on an edge):
  - state<=IDLE, pc<=RESET_PC, instr<=0, instr_pc<=0, instr_valid<=0.
  - imem_req=0.
- IDLE:
  - imem_req=0.
  - Next cycle goes to FETCH unconditionally.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - imem_addr is held stable until ack.
  - On imem_ack=1: instr<=imem_rdata, instr_pc<=pc, instr_valid<=1, state<=VALID.
- VALID:
  - imem_req=0; imem_ack is ignored.
  - If stall=1: hold all outputs, no PC change.
  - If stall=0: pc<=next_pc, instr_valid<=0, state<=FETCH.
- next_pc is evaluated only on the accept cycle. Priority is jump > branch_taken > sequential:
  - jump: {pc_plus4[31:28], jump_target, 2'b00}
  - branch_taken: pc_plus4 + {imm[29:0], 2'b00}; imm is already sign-extended, so negative offsets work. imm[31:30] is discarded.
  - else: pc_plus4
- All PC arithmetic is 32-bit modulo. 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000.
- pc[1:0] is always 2'b00.
- pc_plus4 = instr_pc + 4, combinational.
- Simultaneous jump and branch_taken: jump wins.
- Reset during FETCH or VALID aborts the operation. Any in-flight ack is ignored, since the block is in IDLE with req=0.

## Timing

- Minimum fetch period: 2 cycles per instruction (FETCH with same-cycle ack, then VALID with stall=0).
- Latency from imem_ack to instr_valid=1: 1 cycle (registered).
- Latency from accept to imem_req with the new PC: 1 cycle.
- First imem_req after reset release: 2nd cycle after rst falls (1 cycle in IDLE).
- An imem_ack that arrives N cycles after req adds N cycles to the period. There is no timeout.
- branch_taken, imm, jump and jump_target need only be valid on the accept cycle.

## Structure

- Shared package mips_pkg holds:
  - fetch_state_t enum {IDLE, FETCH, VALID}.
  - The default RESET_PC constant.
  - A PC_INCR=4 constant.
- One sub-module, next_pc_sel: combinational selection of jump, branch and sequential targets. Inputs are pc_plus4, imm, jump_target, jump and branch_taken; output is next_pc.
- The FSM and registers stay in instr_fetch.

## Test plan

- Reset release, ack held at 1, imem_rdata=32'h2008_0005, stall=0 → imem_req on cycle 2 with addr 0. instr_valid on cycle 3 with instr=32'h2008_0005 and instr_pc=0. Next request at addr 4.
- Delayed ack (3 cycles), then stall=1 for 4 cycles → imem_addr stable during the wait; instr and instr_valid held during the stall; no new req until stall=0.
- Branch at instr_pc=32'h40 with imm=32'hFFFF_FFFE → next imem_addr=32'h3C. With imm=32'h0000_0010 → 32'h84.
- Jump and branch_taken both asserted at instr_pc=32'h1000_0000 with jump_target=26'h000_0100 → next addr=32'h1000_0400 (jump wins).
- Sequential fetch at pc=32'hFFFF_FFFC → next imem_addr=32'h0000_0000.
- rst asserted mid-FETCH with ack arriving during IDLE → ack ignored, instr_valid=0, next request at RESET_PC.
